hls_fmul_pipe: RTL and testbench

Fully pipelined, back-pressure-capable successor to the req/ack FP-multiply HLS wrapper. It accepts one 32-bit IEEE-754 multiply per cycle over a valid/ready interface and carries a caller tag through the pipe. It buffers results in an output FIFO so the downstream can stall while the non-stallable core keeps running. It sits between the HLS-generated datapath FSMs and the fpmult_m2 core.

---
 rtl/hls_fp_pkg.sv | 27 ++
 rtl/fpmult_m2.sv | 87 ++++++++
 rtl/hls_tag_fifo.sv | 60 ++++++
 rtl/hls_fmul_pipe.sv | 106 ++++++++++
 tb/tb_hls_fmul_pipe.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hls_fp_pkg.sv
// Shared constants and types for the FP-multiply wrapper and its core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hls_fp_pkg;

    localparam int FP_W         = 32;
    localparam int FMUL_LATENCY = 3;

    // Operand-pair classification decided in the core's first stage
    typedef enum logic [1:0] {
        CLS_NORM,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } fp_cls_t;

    localparam logic [FP_W-1:0] FP_ONE       = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_ONE_HALF  = 32'h3FC0_0000;
    localparam logic [FP_W-1:0] FP_TWO       = 32'h4000_0000;
    localparam logic [FP_W-1:0] FP_THREE     = 32'h4040_0000;
    localparam logic [FP_W-1:0] FP_FOUR      = 32'h4080_0000;
    localparam logic [FP_W-1:0] FP_SIX       = 32'h40C0_0000;
    localparam logic [FP_W-1:0] FP_NEG_TWO   = 32'hC000_0000;
    localparam logic [FP_W-1:0] FP_NEG_THREE = 32'hC040_0000;
    localparam logic [FP_W-1:0] FP_QNAN      = 32'h7FC0_0000;

endpackage

// File: rtl/fpmult_m2.sv
// IEEE-754 single multiply, round-to-nearest-even, subnormals flushed to zero.
// Latency: FMUL_LATENCY (3) cycles from operand sample to res; samples every cycle.
// Backpressure: none, free-running; validity is tracked by the caller.
// Ports: clk, rst (async active-high), a/b operands, res product.
module fpmult_m2
    import hls_fp_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    output logic [FP_W-1:0] res
);

    logic            a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    fp_cls_t         cls_n, s1_cls;
    logic            s1_sign;
    logic [9:0]      s1_exp;
    logic [47:0]     s1_prod;
    logic [23:0]     mant;
    logic            rnd_g, rnd_s;
    logic [24:0]     mant_r;
    logic [9:0]      exp_n, exp_r;
    logic [FP_W-1:0] res_n, s2_res;

    assign a_zero = (a[30:23] == 8'h00);
    assign b_zero = (b[30:23] == 8'h00);
    assign a_inf  = (&a[30:23]) && (a[22:0] == 23'd0);
    assign b_inf  = (&b[30:23]) && (b[22:0] == 23'd0);
    assign a_nan  = (&a[30:23]) && (a[22:0] != 23'd0);
    assign b_nan  = (&b[30:23]) && (b[22:0] != 23'd0);

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) cls_n = CLS_NAN;
        else if (a_inf || b_inf)                                       cls_n = CLS_INF;
        else if (a_zero || b_zero)                                     cls_n = CLS_ZERO;
        else                                                           cls_n = CLS_NORM;
    end

    // Stage 2: normalise the 48-bit product (it lies in [1,4)) and round
    always_comb begin
        res_n = '0;
        if (s1_prod[47]) begin
            mant  = s1_prod[47:24];
            rnd_g = s1_prod[23];
            rnd_s = |s1_prod[22:0];
            exp_n = s1_exp + 10'd1;
        end else begin
            mant  = s1_prod[46:23];
            rnd_g = s1_prod[22];
            rnd_s = |s1_prod[21:0];
            exp_n = s1_exp;
        end
        // Ties go to even; an all-ones mantissa carries into the exponent
        mant_r = {1'b0, mant} + {24'd0, rnd_g & (rnd_s | mant[0])};
        exp_r  = exp_n + {9'd0, mant_r[24]};
        case (s1_cls)
            CLS_NAN:  res_n = FP_QNAN;
            CLS_INF:  res_n = {s1_sign, 8'hFF, 23'd0};
            CLS_ZERO: res_n = {s1_sign, 31'd0};
            default: begin
                if ($signed(exp_r) >= 10'sd255)    res_n = {s1_sign, 8'hFF, 23'd0};
                else if ($signed(exp_r) <= 10'sd0) res_n = {s1_sign, 31'd0};
                else res_n = {s1_sign, exp_r[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_cls  <= CLS_ZERO;
            s1_prod <= '0;
            s2_res  <= '0;
            res     <= '0;
        end else begin
            s1_sign <= a[31] ^ b[31];
            s1_exp  <= {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
            s1_cls  <= cls_n;
            s1_prod <= 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
            s2_res  <= res_n;
            res     <= s2_res;
        end
    end

endmodule

// File: rtl/hls_tag_fifo.sv
// Fall-through sync FIFO of {tag, result} words with occupancy count.
// Latency: push visible at head the cycle after the write edge.
// Backpressure: none internally; the caller's credits guarantee no overflow.
// Ports: push/push_dat write side, pop/head_vld/head_dat read side, count.
module hls_tag_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 36,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [W-1:0]     push_dat,
    input  logic             pop,
    output logic             head_vld,
    output logic [W-1:0]     head_dat,
    output logic [CNT_W-1:0] count
);

    // Storage is rounded up to a power of two so the pointer always indexes it
    // exactly; pointers still wrap at DEPTH, so extra slots stay unused.
    localparam int SLOTS = 1 << PTR_W;

    logic [W-1:0]     mem [SLOTS];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    if (DEPTH < 1) begin : g_bad_depth
        $error("hls_tag_fifo: DEPTH must be at least 1");
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    // Full/empty come from count, never from comparing pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign head_vld = (count != '0);
    assign head_dat = mem[rd_ptr];

    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CNT_W'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && count == '0));

endmodule

// File: rtl/hls_fmul_pipe.sv
// Pipelined FP-multiply wrapper: valid/ready in, tag carried alongside, FIFO-buffered out.
// Latency: accept to out_valid is LATENCY+1 cycles; one op per cycle when credits allow.
// Backpressure: credit counter sized to the FIFO; in_ready drops at zero credits, registered only.
// Ports: in_valid/in_ready/in_tag/p0/p1 in, out_valid/out_ready/out_tag/out out, inflight/idle status.
module hls_fmul_pipe
    import hls_fp_pkg::*;
#(
    parameter  int LATENCY    = FMUL_LATENCY,
    parameter  int TAG_W      = 4,
    parameter  int OBUF_DEPTH = 4,
    localparam int CNT_W      = $clog2(OBUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [FP_W-1:0]  p0,
    input  logic [FP_W-1:0]  p1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic [FP_W-1:0]  out,
    output logic [CNT_W-1:0] inflight,
    output logic             idle
);

    if (LATENCY < 1) begin : g_bad_latency
        $error("hls_fmul_pipe: LATENCY must be at least 1");
    end
    if (LATENCY != FMUL_LATENCY) begin : g_latency_mismatch
        $error("hls_fmul_pipe: LATENCY must match the fpmult_m2 pipeline depth");
    end
    if (OBUF_DEPTH < 1) begin : g_bad_depth
        $error("hls_fmul_pipe: OBUF_DEPTH must be at least 1");
    end

    logic                   accept, pop, core_rst;
    logic [FP_W-1:0]        core_res;
    logic [LATENCY-1:0]     vld_sr;
    logic [TAG_W-1:0]       tag_sr [LATENCY];
    logic [CNT_W-1:0]       credits, fifo_cnt;
    logic [TAG_W+FP_W-1:0]  fifo_head;

    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign core_rst = ~reset;

    // The core samples p0/p1 every cycle; only vld_sr says which results are real
    fpmult_m2 u_core (
        .clk (clk),
        .rst (core_rst),
        .a   (p0),
        .b   (p1),
        .res (core_res)
    );

    // Clearing vld_sr on reset is what drops in-flight ops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= accept;
            for (int i = 1; i < LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_sr[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
    end

    // One credit per FIFO slot, so a write can never find the FIFO full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credits <= CNT_W'(OBUF_DEPTH);
        end else if (accept && !pop) begin
            credits <= credits - CNT_W'(1);
        end else if (pop && !accept) begin
            credits <= credits + CNT_W'(1);
        end
    end

    assign in_ready = (credits != '0);
    assign inflight = CNT_W'(OBUF_DEPTH) - credits;
    assign idle     = (credits == CNT_W'(OBUF_DEPTH));

    hls_tag_fifo #(
        .DEPTH (OBUF_DEPTH),
        .W     (TAG_W + FP_W)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (reset),
        .push     (vld_sr[LATENCY-1]),
        .push_dat ({tag_sr[LATENCY-1], core_res}),
        .pop      (pop),
        .head_vld (out_valid),
        .head_dat (fifo_head),
        .count    (fifo_cnt)
    );

    assign {out_tag, out} = fifo_head;

    a_fifo_within_inflight: assert property (@(posedge clk) disable iff (!reset) fifo_cnt <= inflight);

endmodule

// File: tb/tb_hls_fmul_pipe.sv
module tb_hls_fmul_pipe;
    import hls_fp_pkg::*;

    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] p0 = '0;
    logic [31:0] p1 = '0;

    // a_*: default build (depth 4)
    logic             a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic             a_in_ready, a_out_valid, a_idle;
    logic [TAG_W-1:0] a_in_tag = '0, a_out_tag;
    logic [31:0]      a_out;
    logic [2:0]       a_inflight;
    // s_*: depth 5. A credit is away for LATENCY+2 cycles (accept, pipe,
    // FIFO write, pop, registered return), so this is the depth that sustains
    // one accept per cycle without in_ready ever dropping.
    logic             s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic             s_in_ready, s_out_valid, s_idle;
    logic [TAG_W-1:0] s_in_tag = '0, s_out_tag;
    logic [31:0]      s_out;
    logic [2:0]       s_inflight;
    // n_*: depth 1
    logic             n_in_valid = 1'b0, n_out_ready = 1'b0;
    logic             n_in_ready, n_out_valid, n_idle;
    logic [TAG_W-1:0] n_in_tag = '0, n_out_tag;
    logic [31:0]      n_out;
    logic [0:0]       n_inflight;

    hls_fmul_pipe #(.LATENCY(3), .TAG_W(TAG_W), .OBUF_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_tag(a_in_tag),
        .p0(p0), .p1(p1), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_tag(a_out_tag),
        .out(a_out), .inflight(a_inflight), .idle(a_idle));

    hls_fmul_pipe #(.LATENCY(3), .TAG_W(TAG_W), .OBUF_DEPTH(5)) dut_s (
        .clk(clk), .reset(reset), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_tag(s_in_tag),
        .p0(p0), .p1(p1), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_tag(s_out_tag),
        .out(s_out), .inflight(s_inflight), .idle(s_idle));

    hls_fmul_pipe #(.LATENCY(3), .TAG_W(TAG_W), .OBUF_DEPTH(1)) dut_n (
        .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready), .in_tag(n_in_tag),
        .p0(p0), .p1(p1), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_tag(n_out_tag),
        .out(n_out), .inflight(n_inflight), .idle(n_idle));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int acc, got, first, last;
    logic found;
    logic [31:0] exp_tag [2];
    logic [31:0] exp_val [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // ---------------- reset state ----------------
        check("rst_in_ready", 32'(a_in_ready), 1);
        check("rst_out_valid", 32'(a_out_valid), 0);
        check("rst_inflight", 32'(a_inflight), 0);
        check("rst_idle", 32'(a_idle), 1);
        check("rst_n_in_ready", 32'(n_in_ready), 1);
        reset = 1'b1;
        step();

        // ---------------- single op: 2.0 * 3.0, tag 5 ----------------
        a_out_ready = 1'b1;
        p0 = FP_TWO; p1 = FP_THREE; a_in_tag = 4'd5; a_in_valid = 1'b1;
        check("single_rdy", 32'(a_in_ready), 1);
        step();
        a_in_valid = 1'b0;
        check("single_busy", 32'(a_idle), 0);
        check("single_infl", 32'(a_inflight), 1);
        check("single_ov_c1", 32'(a_out_valid), 0);
        step();
        check("single_ov_c2", 32'(a_out_valid), 0);
        step();
        check("single_ov_c3", 32'(a_out_valid), 0);
        step();
        check("single_ov_c4", 32'(a_out_valid), 1);
        check("single_dat", a_out, FP_SIX);
        check("single_tag", 32'(a_out_tag), 5);
        step();
        check("single_idle", 32'(a_idle), 1);
        check("single_ov_after", 32'(a_out_valid), 0);
        check("single_infl_after", 32'(a_inflight), 0);

        // ---------------- streaming 16 ops: 1.5 * -2.0 ----------------
        s_out_ready = 1'b1;
        p0 = FP_ONE_HALF; p1 = FP_NEG_TWO;
        got = 0; first = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (s_out_valid) begin
                if (first < 0) first = cyc;
                check("stream_dat", s_out, FP_NEG_THREE);
                check("stream_tag", 32'(s_out_tag), got);
                check("stream_gap", cyc, first + got);
                got++;
            end
            if (cyc < 16) begin
                s_in_valid = 1'b1;
                s_in_tag = TAG_W'(cyc);
                check("stream_rdy", 32'(s_in_ready), 1);
            end else begin
                s_in_valid = 1'b0;
            end
            step();
        end
        check("stream_cnt", got, 16);
        check("stream_first", first, 4);

        // ---------------- back-pressure: 2.0 * 2.0, downstream stalled ----------------
        a_out_ready = 1'b0;
        p0 = FP_TWO; p1 = FP_TWO;
        acc = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a_in_valid = 1'b1;
            a_in_tag = TAG_W'(acc);
            if (a_in_ready) acc++;
            step();
        end
        check("bp_accepts", acc, 4);
        check("bp_rdy", 32'(a_in_ready), 0);
        check("bp_infl", 32'(a_inflight), 4);
        check("bp_ov", 32'(a_out_valid), 1);
        check("bp_head", 32'(a_out_tag), 0);
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;
        // The freed credit shows up the cycle after the pop
        check("bp_pop_rdy", 32'(a_in_ready), 1);
        check("bp_pop_infl", 32'(a_inflight), 3);
        check("bp_pop_head", 32'(a_out_tag), 1);
        a_in_tag = 4'd4;
        step();
        a_in_valid = 1'b0;
        check("bp_refill_rdy", 32'(a_in_ready), 0);
        check("bp_refill_infl", 32'(a_inflight), 4);
        a_out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (a_out_valid) begin
                check("bp_drain_tag", 32'(a_out_tag), got + 1);
                check("bp_drain_dat", a_out, FP_FOUR);
                got++;
            end
            step();
        end
        check("bp_drain_cnt", got, 4);
        check("bp_drain_idle", 32'(a_idle), 1);

        // ---------------- accept and pop in the same cycle, FIFO at 2 ----------------
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_tag = 4'd8;
        step();
        a_in_tag = 4'd9;
        step();
        a_in_valid = 1'b0;
        repeat (5) step();
        check("sim_ov", 32'(a_out_valid), 1);
        check("sim_infl_pre", 32'(a_inflight), 2);
        check("sim_head_pre", 32'(a_out_tag), 8);
        check("sim_dat_pre", a_out, FP_FOUR);
        a_in_valid = 1'b1; a_in_tag = 4'd10; a_out_ready = 1'b1;
        p0 = FP_ONE; p1 = FP_THREE;
        step();
        a_in_valid = 1'b0;
        check("sim_infl", 32'(a_inflight), 2);
        check("sim_head", 32'(a_out_tag), 9);
        exp_tag[0] = 32'd9;  exp_val[0] = FP_FOUR;
        exp_tag[1] = 32'd10; exp_val[1] = FP_THREE;
        got = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (a_out_valid) begin
                if (got < 2) begin
                    check("sim_drain_tag", 32'(a_out_tag), exp_tag[got]);
                    check("sim_drain_dat", a_out, exp_val[got]);
                end
                got++;
            end
            step();
        end
        check("sim_drain_cnt", got, 2);
        check("sim_idle", 32'(a_idle), 1);

        // ---------------- reset mid-flight ----------------
        p0 = FP_TWO; p1 = FP_THREE;
        a_in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_in_tag = TAG_W'(i);
            step();
        end
        a_in_valid = 1'b0;
        check("mid_infl_pre", 32'(a_inflight), 3);
        reset = 1'b0;
        #1;
        check("mid_rst_rdy", 32'(a_in_ready), 1);
        check("mid_rst_idle", 32'(a_idle), 1);
        step();
        step();
        reset = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            check("mid_quiet_ov", 32'(a_out_valid), 0);
            step();
        end
        check("mid_infl", 32'(a_inflight), 0);
        check("mid_rdy", 32'(a_in_ready), 1);
        p0 = FP_TWO; p1 = FP_TWO;
        a_in_valid = 1'b1; a_in_tag = 4'd7;
        step();
        a_in_valid = 1'b0;
        found = 1'b0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (a_out_valid && !found) begin
                found = 1'b1;
                check("mid_new_dat", a_out, FP_FOUR);
                check("mid_new_tag", 32'(a_out_tag), 7);
            end
            step();
        end
        check("mid_new_seen", 32'(found), 1);
        check("mid_new_idle", 32'(a_idle), 1);

        // ---------------- depth 1: one result every 5 cycles ----------------
        n_out_ready = 1'b1;
        p0 = FP_THREE; p1 = FP_TWO;
        acc = 0; got = 0; last = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (n_out_valid) begin
                check("sweep_dat", n_out, FP_SIX);
                check("sweep_tag", 32'(n_out_tag), got);
                if (got > 0) check("sweep_gap", cyc - last, 5);
                last = cyc;
                got++;
            end
            n_in_valid = (acc < 6);
            n_in_tag = TAG_W'(acc);
            if (n_in_valid && n_in_ready) acc++;
            step();
        end
        n_in_valid = 1'b0;
        check("sweep_accepts", acc, 6);
        check("sweep_results", got, 6);
        check("sweep_idle", 32'(n_idle), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
